// File: rtl/up_counter_mod.sv
// up_counter_mod: parameterized up counter with load, modulo-N terminal value, wrap/saturate, wrap pulse and sticky overflow
//   clk        rising-edge clock
//   clear_n    asynchronous active-low reset
//   en         count enable
//   load       synchronous load strobe (beats en)
//   load_value value captured on load
//   max_value  terminal value; sequence is 0..max_value
//   sat_mode   1 = saturate at max_value, 0 = wrap to 0
//   clr_sticky synchronous clear of overflow
//   count      registered count
//   tc         combinational terminal count (count >= max_value)
//   wrap_pulse registered pulse, high while count shows 0 after a wrap
//   overflow   sticky, set by an increment attempted at or above terminal
module up_counter_mod #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  input  logic             sat_mode,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             overflow
);
  logic             hit;
  logic [WIDTH-1:0] count_nxt;
  assign tc = count >= max_value;
  // hit: an increment attempted at or beyond the terminal value
  assign hit = !load && en && tc;
  always_comb begin
    count_nxt = load ? load_value :
                hit  ? (sat_mode ? max_value : '0) :
                en   ? count + WIDTH'(1) : count;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap_pulse <= hit && !sat_mode;
      overflow   <= hit || (overflow && !clr_sticky);
    end
  end
endmodule

// File: doc/up_counter_mod.md
Name: up_counter_mod

Overview:
- Parameterized up counter: the counting-up counterpart of the team's down counter, for the counters library.
- Adds enable, synchronous parallel load, a programmable terminal value (modulo-N), selectable wrap or saturate mode, a registered wrap pulse and a sticky overflow flag.
- Used as a timebase or prescaler and as an event counter by the up/down counter wrappers that select between counter directions by mux.

Parameters:
- WIDTH, default 4: counter width in bits; legal range 2..32.

Ports:
- clk, input, 1: rising-edge clock.
- clear_n, input, 1: asynchronous active-low reset.
- en, input, 1: count enable; advance by one per cycle while high.
- load, input, 1: synchronous load strobe.
- load_value, input, WIDTH: value captured when load=1.
- max_value, input, WIDTH: terminal value; counter sequence is 0..max_value. Quasi-static.
- sat_mode, input, 1: 1 = saturate at max_value; 0 = wrap to 0.
- clr_sticky, input, 1: synchronous clear of overflow.
- count, output, WIDTH: current count; registered.
- tc, output, 1: terminal count, combinational. tc = (count >= max_value), unsigned compare.
- wrap_pulse, output, 1: registered one-cycle pulse. High in the cycle count shows 0 as a result of a wrap.
- overflow, output, 1: sticky flag. Set when an increment is attempted at or above terminal.

Behaviour:
- Reset:
  - clear_n low asynchronously forces count=0, wrap_pulse=0, overflow=0, independent of clk.
  - Release is synchronous to clk. The first update happens on the first rising edge with clear_n high.
- Priority per rising edge: load > en > hold.
- load=1:
  - count <= load_value, even if load_value > max_value.
  - wrap_pulse <= 0. overflow is not set by load.
- load=0, en=1, count < max_value: count <= count+1, wrap_pulse <= 0.
- load=0, en=1, count >= max_value (tc=1):
  - In all modes, overflow <= 1.
  - sat_mode=0: count <= 0, wrap_pulse <= 1.
  - sat_mode=1: count <= max_value (holds if equal, clamps if above); wrap_pulse <= 0.
- load=0, en=0: count holds, wrap_pulse <= 0.
- All arithmetic is WIDTH bits, unsigned. Natural 2^WIDTH rollover never occurs, because the counter always stops at or wraps from max_value.
  - max_value = all-ones gives a full-range counter.
  - max_value = 0: wrap mode holds count at 0 and pulses wrap_pulse on every enabled cycle; saturate mode holds at 0. overflow sets on the first enabled cycle.
- Latency: count, wrap_pulse and overflow update one cycle after the qualifying edge. tc follows count combinationally.
- overflow:
  - Cleared only by clear_n or by clr_sticky=1 at a rising edge.
  - Set has priority over clr_sticky when both occur on the same edge.
- sat_mode and max_value may change at any time. They take effect from the next edge; there is no retroactive correction.
- All outputs are driven from registers except tc. No latches, no combinational loops.

Test Plan:
1. Reset and count:
   - Stimulus: WIDTH=4, max_value=9, sat_mode=0. Assert clear_n=0 mid-count with no clk edge, then release; en=1 for 12 cycles.
   - Required: count=0 immediately on reset; then 1..9,0,1,2.
   - Required: tc=1 only while count=9; wrap_pulse=1 only in the cycle count=0 after 9; overflow=1 from that cycle on.
2. Saturate and clamp:
   - Stimulus: max_value=5, sat_mode=1, en=1 for 8 cycles.
   - Required: count 1..5 then holds at 5; wrap_pulse stays 0; overflow=1 after the first enabled edge at 5.
   - Stimulus: then load 12 followed by en=1.
   - Required: count=12 with tc=1, then count=5.
3. Load priority:
   - Stimulus: count=3, load=1 with load_value=7 and en=1 on the same edge.
   - Required: count=7, no increment.
   - Stimulus: with sat_mode=0 and max_value=9, load 14 then en=1.
   - Required: count=0, wrap_pulse=1.
4. Sticky semantics:
   - Stimulus: overflow=1, clr_sticky=1 on an edge with no wrap.
   - Required: overflow=0.
   - Stimulus: clr_sticky=1 on the same edge as a wrap.
   - Required: overflow stays 1.
5. Edge values:
   - Stimulus: max_value=15, sat_mode=0, 17 enabled cycles.
   - Required: 1..15,0,1, with a single wrap_pulse.
   - Stimulus: max_value=0, wrap mode.
   - Required: count stays 0, wrap_pulse=1 on every enabled cycle.
6. Enable gating:
   - Stimulus: en toggled 1,0,0,1 from count=2, max_value=9.
   - Required: count 3,3,3,4; wrap_pulse stays 0.
